// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared definitions for the EX-stage sequential divider: FSM state encoding,
// result-ready levels, stall request levels and the reset-enable level.
// No ports (package).
// -----------------------------------------------------------------------------
package div_seq_pkg;

    // Divider sequencer states (2-bit encoding)
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,  // idle, waiting for a request
        DIV_BYZERO = 2'b01,  // divisor was zero, result forced to 0
        DIV_ON     = 2'b10,  // iterating one quotient bit per clock
        DIV_END    = 2'b11   // result valid, held until start_i drops
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Levels EX drives into its stall vector while waiting on the divider
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // Active level of the codebase's synchronous reset
    localparam logic RST_ENA = 1'b1;

endpackage : div_seq_pkg

// File: rtl/div_seq_if.sv
// -----------------------------------------------------------------------------
// div_seq_if
// Request/result bundle between the EX stage (master) and the divider
// sequencer (slave).
//   signed_div_i : 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held high by EX until ready_o is seen
//   annul_i      : cancel an in-flight division
//   result_o     : {remainder, quotient} = {HI, LO}
//   ready_o      : result valid
// -----------------------------------------------------------------------------
interface div_seq_if #(
    parameter int DATA_W = 32
);

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );

endinterface : div_seq_if

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Multi-cycle radix-2 restoring divider sequencer for the EX stage (DIV/DIVU).
// Takes DATA_W iterations after acceptance plus one cycle for sign fixup, so
// a request sampled at edge k produces ready_o after edge k+DATA_W+1.
// Divide-by-zero completes after one cycle with a zero result.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : div_seq_if.slave (operands, start/annul in; result/ready out)
// -----------------------------------------------------------------------------
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    div_state_e              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [2*DATA_W:0]       r_dividend;   // {partial remainder, dividend/quotient, spare}
    logic [DATA_W-1:0]       r_divisor;    // divisor magnitude
    logic                    r_signed;
    logic                    r_op1_msb;    // sign of the original dividend
    logic                    r_op2_msb;    // sign of the original divisor
    logic [2*DATA_W-1:0]     r_result;
    logic                    r_ready;

    logic [DATA_W:0]         w_diff;
    logic [DATA_W-1:0]       w_mag1;
    logic [DATA_W-1:0]       w_mag2;
    logic [DATA_W-1:0]       w_quot;
    logic [DATA_W-1:0]       w_rem;

    // Trial subtraction; the extra top bit is the borrow (1 = divisor larger)
    assign w_diff = {1'b0, r_dividend[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};

    // Operand magnitudes, taken only when the operation is signed and negative
    assign w_mag1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i
                                                                  :  bus.opdata1_i;
    assign w_mag2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i
                                                                  :  bus.opdata2_i;

    // Sign fixup: quotient negative when signs differ, remainder follows dividend
    assign w_quot = (r_signed && (r_op1_msb != r_op2_msb)) ? -r_dividend[DATA_W-1:0]
                                                           :  r_dividend[DATA_W-1:0];
    assign w_rem  = (r_signed && r_op1_msb) ? -r_dividend[2*DATA_W:DATA_W+1]
                                            :  r_dividend[2*DATA_W:DATA_W+1];

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            r_state    <= DIV_FREE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_signed   <= 1'b0;
            r_op1_msb  <= 1'b0;
            r_op2_msb  <= 1'b0;
            r_result   <= '0;
            r_ready    <= DIV_RESULT_NOT_READY;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    r_ready  <= DIV_RESULT_NOT_READY;
                    r_result <= '0;
                    // annul_i alongside start_i means the request is not accepted
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            r_state <= DIV_BYZERO;
                        end else begin
                            r_state    <= DIV_ON;
                            r_cnt      <= '0;
                            r_signed   <= bus.signed_div_i;
                            r_op1_msb  <= bus.opdata1_i[DATA_W-1];
                            r_op2_msb  <= bus.opdata2_i[DATA_W-1];
                            r_dividend <= {{DATA_W{1'b0}}, w_mag1, 1'b0};
                            r_divisor  <= w_mag2;
                        end
                    end
                end

                DIV_BYZERO: begin
                    r_result <= '0;
                    if (bus.annul_i) begin
                        r_state <= DIV_FREE;
                        r_ready <= DIV_RESULT_NOT_READY;
                    end else begin
                        r_state <= DIV_END;
                        r_ready <= DIV_RESULT_READY;
                    end
                end

                DIV_ON: begin
                    if (bus.annul_i) begin
                        r_state  <= DIV_FREE;
                        r_ready  <= DIV_RESULT_NOT_READY;
                        r_result <= '0;
                    end else if (r_cnt != LAST_CNT) begin
                        // Restore by simply not committing the difference
                        if (w_diff[DATA_W]) begin
                            r_dividend <= {r_dividend[2*DATA_W-1:0], 1'b0};
                        end else begin
                            r_dividend <= {w_diff[DATA_W-1:0], r_dividend[DATA_W-1:0], 1'b1};
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_result <= {w_rem, w_quot};
                        r_ready  <= DIV_RESULT_READY;
                        r_state  <= DIV_END;
                    end
                end

                DIV_END: begin
                    // annul_i deliberately ignored: the result is already final
                    if (!bus.start_i) begin
                        r_state  <= DIV_FREE;
                        r_ready  <= DIV_RESULT_NOT_READY;
                        r_result <= '0;
                    end
                end

                default: begin
                    r_state <= DIV_FREE;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

endmodule : div_seq

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
// Self-checking bench for div_seq: directed table, hand-written corner
// sequences (annul, byzero annul, reset mid-op and in END) and randomized
// operations compared with an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div_seq;

    localparam int W = 32;

    logic clk;
    logic rst;

    div_seq_if #(.DATA_W(W)) bus ();

    div_seq #(.DATA_W(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: divide magnitudes with plain arithmetic, then apply sign rules
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        bit neg_a, neg_b;
        longint unsigned ma, mb, q, r;
        if (b == 32'h0) return 64'h0;
        neg_a = sgn && a[31];
        neg_b = sgn && b[31];
        ma = neg_a ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
        mb = neg_b ? (64'h1_0000_0000 - longint'(b)) : longint'(b);
        q  = ma / mb;
        r  = ma % mb;
        if (neg_a != neg_b) q = -q;
        if (neg_a) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    // One complete handshake. Operands are scrambled right after acceptance.
    // During the hold phase annul_i is raised to confirm END ignores it.
    task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int hold);
        int e;
        int exp_lat;
        exp_lat = (b == 32'h0) ? 1 : W + 1;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        tick();  // edge k: request sampled
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sgn;
        e = 0;
        while (bus.ready_o !== 1'b1 && e < 100) begin
            tick();
            e++;
        end
        check({name, " latency"}, 64'(e), 64'(exp_lat));
        check({name, " result"}, bus.result_o, exp);
        for (int i = 0; i < hold; i++) begin
            bus.annul_i = i[0];
            tick();
            check({name, " hold ready"}, {63'h0, bus.ready_o}, 64'h1);
            check({name, " hold result"}, bus.result_o, exp);
        end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        tick();
        check({name, " drop ready"}, {63'h0, bus.ready_o}, 64'h0);
        check({name, " drop result"}, bus.result_o, 64'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hits;
        bit sgn;
        logic [31:0] a, b;

        vecs[0] = '{"divu_100_7",     1'b0, 32'd100,       32'd7,         32'h0000000E, 32'h00000002};
        vecs[1] = '{"div_m7_2",       1'b1, 32'hFFFFFFF9,  32'h00000002,  32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2] = '{"div_7_m2",       1'b1, 32'h00000007,  32'hFFFFFFFE,  32'hFFFFFFFD, 32'h00000001};
        vecs[3] = '{"div_5_0",        1'b1, 32'd5,         32'd0,         32'h00000000, 32'h00000000};
        vecs[4] = '{"div_ovf",        1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000};
        vecs[5] = '{"divu_max_1",     1'b0, 32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFF, 32'h00000000};
        vecs[6] = '{"divu_8000_ffff", 1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h00000000, 32'h80000000};
        vecs[7] = '{"div_m100_m7",    1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'h0000000E, 32'hFFFFFFFE};
        vecs[8] = '{"div_min_1",      1'b1, 32'h80000000,  32'h00000001,  32'h80000000, 32'h00000000};

        // Reset state
        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) tick();
        check("reset ready", {63'h0, bus.ready_o}, 64'h0);
        check("reset result", bus.result_o, 64'h0);
        rst = 1'b0;
        tick();

        // Directed table; the first entry also exercises a 5-cycle hold in END
        foreach (vecs[i]) begin
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    {vecs[i].r, vecs[i].q}, (i == 0) ? 5 : 1);
        end

        // Annul at iteration 10: back to FREE, annul+start not accepted
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        tick();
        repeat (10) tick();
        bus.annul_i = 1'b1;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.ready_o !== 1'b0) hits++;
        end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) hits++;
        end
        check("annul on no ready", 64'(hits), 64'h0);
        run_div("after annul 9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 0);

        // Annul while in BYZERO: ready_o must never rise
        bus.signed_div_i = 1'b1;
        bus.opdata1_i    = 32'd5;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b1;
        tick();
        bus.annul_i = 1'b1;
        tick();
        check("annul byzero ready", {63'h0, bus.ready_o}, 64'h0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        tick();
        check("annul byzero idle", {63'h0, bus.ready_o}, 64'h0);

        // Reset at iteration 20 discards the work
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        tick();
        repeat (20) tick();
        rst = 1'b1;
        bus.start_i = 1'b0;
        tick();
        check("rst mid ready", {63'h0, bus.ready_o}, 64'h0);
        check("rst mid result", bus.result_o, 64'h0);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ready_o !== 1'b0) hits++;
        end
        check("rst mid no ready", 64'(hits), 64'h0);

        // Reset while holding a result in END
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        hits = 0;
        tick();
        while (bus.ready_o !== 1'b1 && hits < 100) begin
            tick();
            hits++;
        end
        check("pre-rst result", bus.result_o, {32'd1, 32'd333});
        rst = 1'b1;
        tick();
        check("rst end ready", {63'h0, bus.ready_o}, 64'h0);
        check("rst end result", bus.result_o, 64'h0);
        rst = 1'b0;
        bus.start_i = 1'b0;
        tick();

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 15);
                2:       b = -32'($urandom_range(1, 15));
                3:       b = 32'h0;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_div($sformatf("rand%0d", n), sgn, a, b, ref_div(sgn, a, b), n % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_seq
